// File: rtl/module_4_pkg.sv
// rtl/module_4_pkg.sv - shared dataflow sizes and one-hot FSM state constants
package module_4_pkg;

    localparam int N      = 5;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    localparam logic [4:0] ST_S1 = 5'd1;
    localparam logic [4:0] ST_S2 = 5'd2;
    localparam logic [4:0] ST_S3 = 5'd4;
    localparam logic [4:0] ST_S4 = 5'd8;
    localparam logic [4:0] ST_S5 = 5'd16;

    localparam logic [ADDR_W:0] I_LAST = (ADDR_W + 1)'(N);

endpackage

// File: rtl/module_4_if.sv
// rtl/module_4_if.sv - block-level handshake plus E read / F write memory ports
interface module_4_if;
    import module_4_pkg::*;

    logic              ap_start;
    logic              ap_done;
    logic              ap_continue;
    logic              ap_idle;
    logic              ap_ready;
    logic [ADDR_W-1:0] E_address0;
    logic              E_ce0;
    logic [DATA_W-1:0] E_q0;
    logic [ADDR_W-1:0] F_address0;
    logic              F_ce0;
    logic              F_we0;
    logic [DATA_W-1:0] F_d0;
    logic [DATA_W-1:0] total;
    logic              total_ap_vld;

    modport master (
        output ap_start, ap_continue, E_q0,
        input  ap_done, ap_idle, ap_ready, E_address0, E_ce0,
        input  F_address0, F_ce0, F_we0, F_d0, total, total_ap_vld
    );

    modport slave (
        input  ap_start, ap_continue, E_q0,
        output ap_done, ap_idle, ap_ready, E_address0, E_ce0,
        output F_address0, F_ce0, F_we0, F_d0, total, total_ap_vld
    );

endinterface

// File: rtl/module_4.sv
// rtl/module_4.sv - prefix-sum dataflow stage: F[i] = sum(E[0..i]), total = sum(E)
module module_4
    import module_4_pkg::*;
(
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    module_4_if.slave   bus
);

    logic [4:0]        state;
    logic              done_reg;
    logic [ADDR_W:0]   i;
    logic [ADDR_W:0]   i_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] e_reg;
    logic [DATA_W-1:0] sum_reg;
    logic              in_s2;
    logic              s2_exit;

    assign in_s2   = (state == ST_S2);
    assign s2_exit = in_s2 && (i == I_LAST);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= ST_S1;
            i        <= '0;
            i_next   <= '0;
            addr_reg <= '0;
            acc      <= '0;
            e_reg    <= '0;
            sum_reg  <= '0;
        end else begin
            case (state)
                ST_S1: begin
                    if (bus.ap_start && !done_reg) begin
                        i     <= '0;
                        acc   <= '0;
                        state <= ST_S2;
                    end
                end
                ST_S2: begin
                    if (i == I_LAST) begin
                        state <= ST_S1;
                    end else begin
                        addr_reg <= i[ADDR_W-1:0];
                        i_next   <= i + (ADDR_W + 1)'(1);
                        state    <= ST_S3;
                    end
                end
                ST_S3: begin
                    e_reg <= bus.E_q0;
                    state <= ST_S4;
                end
                ST_S4: begin
                    sum_reg <= acc + e_reg;
                    state   <= ST_S5;
                end
                ST_S5: begin
                    acc   <= sum_reg;
                    i     <= i_next;
                    state <= ST_S2;
                end
                default: state <= ST_S1;
            endcase
        end
    end

    // continue wins over a same-cycle completion so the channel can acknowledge early
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            done_reg <= 1'b0;
        end else if (bus.ap_continue) begin
            done_reg <= 1'b0;
        end else if (s2_exit) begin
            done_reg <= 1'b1;
        end
    end

    assign bus.E_ce0        = in_s2 && (i != I_LAST);
    assign bus.E_address0   = i[ADDR_W-1:0];
    assign bus.F_ce0        = (state == ST_S5);
    assign bus.F_we0        = (state == ST_S5);
    assign bus.F_address0   = addr_reg;
    assign bus.F_d0         = sum_reg;
    assign bus.ap_done      = s2_exit || done_reg;
    assign bus.ap_ready     = s2_exit;
    assign bus.ap_idle      = (state == ST_S1) && !bus.ap_start;
    assign bus.total        = acc;
    assign bus.total_ap_vld = s2_exit;

endmodule

// File: tb/tb_module_4.sv
// tb/tb_module_4.sv - randomized self-checking bench for module_4 against a prefix-sum model
module tb_module_4;
    import module_4_pkg::*;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    logic [DATA_W-1:0] mem [N];

    module_4_if bus();

    module_4 dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // E memory: one-cycle read latency
    always @(posedge clk) begin
        if (bus.E_ce0) bus.E_q0 <= mem[bus.E_address0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic load(input logic [31:0] a, b, c, d, e);
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d; mem[4] = e;
    endtask

    task automatic run_check(input string tag, input bit cont);
        logic [DATA_W-1:0] pre [N];
        logic [DATA_W-1:0] s;
        int nw;
        int done_c;
        s = '0;
        for (int k = 0; k < N; k++) begin
            s = s + mem[k];
            pre[k] = s;
        end
        @(negedge clk);
        bus.ap_start    = 1'b1;
        bus.ap_continue = cont;
        nw     = 0;
        done_c = -1;
        for (int c = 1; c <= 60 && done_c < 0; c++) begin
            @(negedge clk);
            bus.ap_start = 1'b0;
            if (bus.F_we0) begin
                if (nw < N) begin
                    check({tag, "_faddr"}, 32'(bus.F_address0), 32'(nw));
                    check({tag, "_fdata"}, bus.F_d0, pre[nw]);
                    check({tag, "_fcycle"}, 32'(c), 32'(4 + 4 * nw));
                end
                nw++;
            end
            if (bus.ap_done) begin
                done_c = c;
                check({tag, "_ready"}, 32'(bus.ap_ready), 32'd1);
                check({tag, "_vld"}, 32'(bus.total_ap_vld), 32'd1);
                check({tag, "_total"}, bus.total, pre[N-1]);
            end
        end
        check({tag, "_nwrites"}, 32'(nw), 32'(N));
        check({tag, "_done_cycle"}, 32'(done_c), 32'(4 * N + 1));
    endtask

    initial begin
        int prev;
        int pulses;
        n_total = 0;
        n_pass  = 0;
        rst_n           = 1'b0;
        bus.ap_start    = 1'b0;
        bus.ap_continue = 1'b0;
        load(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_done", 32'(bus.ap_done), 0);
        check("rst_idle", 32'(bus.ap_idle), 1);
        check("rst_ready", 32'(bus.ap_ready), 0);
        check("rst_ece", 32'(bus.E_ce0), 0);
        check("rst_fce", 32'(bus.F_ce0), 0);
        check("rst_vld", 32'(bus.total_ap_vld), 0);
        check("rst_total", bus.total, 0);
        rst_n = 1'b1;

        load(1, 4, 9, 16, 25);
        run_check("squares", 1'b1);

        load(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
        run_check("wrap", 1'b1);

        load(-32'sd3, 32'sd1, -32'sd1, 32'sd5, -32'sd2);
        run_check("signed", 1'b1);

        for (int r = 0; r < 6; r++) begin
            load($urandom, $urandom, $urandom, $urandom, $urandom);
            run_check("rand", 1'b1);
        end

        load(1, 4, 9, 16, 25);
        run_check("hold", 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.ap_start = 1'b1;
            #1;
            check("hold_done", 32'(bus.ap_done), 1);
            check("hold_idle", 32'(bus.ap_idle), 0);
            check("hold_ece", 32'(bus.E_ce0), 0);
        end
        @(negedge clk);
        bus.ap_start    = 1'b0;
        bus.ap_continue = 1'b1;
        @(negedge clk);
        bus.ap_continue = 1'b0;
        check("cont_clears_done", 32'(bus.ap_done), 0);
        run_check("restart", 1'b1);

        load(1, 4, 9, 16, 25);
        @(negedge clk);
        bus.ap_start    = 1'b1;
        bus.ap_continue = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus.ap_start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_ece", 32'(bus.E_ce0), 0);
        check("midrst_fce", 32'(bus.F_ce0), 0);
        check("midrst_fwe", 32'(bus.F_we0), 0);
        check("midrst_done", 32'(bus.ap_done), 0);
        check("midrst_ready", 32'(bus.ap_ready), 0);
        check("midrst_vld", 32'(bus.total_ap_vld), 0);
        check("midrst_idle", 32'(bus.ap_idle), 1);
        check("midrst_total", bus.total, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("post_rst", 1'b1);

        @(negedge clk);
        bus.ap_start    = 1'b1;
        bus.ap_continue = 1'b1;
        prev   = -1;
        pulses = 0;
        for (int c = 1; c <= 120 && pulses < 3; c++) begin
            @(negedge clk);
            if (bus.total_ap_vld) begin
                check("b2b_total", bus.total, 32'd55);
                if (prev < 0) check("b2b_first", 32'(c), 32'(4 * N + 1));
                else          check("b2b_period", 32'(c - prev), 32'(4 * N + 2));
                prev = c;
                pulses++;
                if (pulses == 3) bus.ap_start = 1'b0;
            end
        end
        bus.ap_start = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd3);
        repeat (2) @(negedge clk);
        check("b2b_idle", 32'(bus.ap_idle), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
